// File: rtl/usb_rx_pkg.sv
// Shared types and defaults for the USB RX bit decoder: FSM states,
// line-code classification and the bit-stuffing limit.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RCV  = 2'd1,
    EOP1 = 2'd2,
    EOP2 = 2'd3
  } rx_dec_state_t;

  typedef enum logic [1:0] {
    LC_J   = 2'd0,
    LC_K   = 2'd1,
    LC_SE0 = 2'd2
  } line_code_t;

  localparam int STUFF_LIMIT_DEF = 6;

  // Equal D+/D- levels (including the illegal SE1) are treated as SE0.
  function automatic line_code_t classify(input logic dp, input logic dm, input logic idle_dp);
    line_code_t lc;
    if (dp == dm) begin
      lc = LC_SE0;
    end else if (dp == idle_dp) begin
      lc = LC_J;
    end else begin
      lc = LC_K;
    end
    return lc;
  endfunction

endpackage

// File: rtl/rx_unstuffer.sv
// NRZI decoder and consecutive-ones counter; flags stuff-bit positions
// and stuff violations for the byte assembler in rx_bit_decoder.
module rx_unstuffer
  import usb_rx_pkg::*;
#(
  parameter int STUFF_LIMIT = STUFF_LIMIT_DEF,
  parameter bit IDLE_DP     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_plus,
  input  logic decode,
  input  logic clear,
  output logic dbit,
  output logic dbit_valid,
  output logic stuff_viol
);

  localparam int OW = $clog2(STUFF_LIMIT + 1);
  localparam logic [OW-1:0] LIMIT = OW'(STUFF_LIMIT);

  logic          prev_bit_q, prev_bit_d;
  logic [OW-1:0] ones_q, ones_d;
  logic          is_stuff;

  // Outputs are kept apart from the next-state logic so that the top's
  // clear (which depends on stuff_viol) forms no combinational loop.
  assign dbit       = (d_plus == prev_bit_q);
  assign is_stuff   = (ones_q == LIMIT);
  assign dbit_valid = decode && !is_stuff;
  assign stuff_viol = decode && is_stuff && dbit;

  always_comb begin
    prev_bit_d = prev_bit_q;
    ones_d     = ones_q;
    if (clear) begin
      prev_bit_d = IDLE_DP;
      ones_d     = '0;
    end else if (decode) begin
      prev_bit_d = d_plus;
      if (is_stuff) begin
        ones_d = '0;
      end else if (dbit) begin
        ones_d = ones_q + OW'(1);
      end else begin
        ones_d = '0;
      end
    end else begin
      prev_bit_d = prev_bit_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_bit_q <= IDLE_DP;
      ones_q     <= '0;
    end else begin
      prev_bit_q <= prev_bit_d;
      ones_q     <= ones_d;
    end
  end

endmodule

// File: rtl/rx_bit_decoder.sv
// USB RX bit decoder: line sampling, unstuffing, LSB-first byte assembly and
// EOP detection. Define RX_STUFF_ERR_EN to abort packets on stuff violations.
module rx_bit_decoder
  import usb_rx_pkg::*;
#(
  parameter int STUFF_LIMIT = STUFF_LIMIT_DEF,
  parameter bit IDLE_DP     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_plus,
  input  logic       d_minus,
  input  logic       en_sample,
  output logic       rx_active,
  output logic [7:0] rx_byte,
  output logic       byte_ready,
  output logic       eop,
  output logic       rx_err,
  output logic       stuff_err
);

  rx_dec_state_t state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_active_q, rx_active_d;
  logic          byte_ready_q, byte_ready_d;
  logic          eop_q, eop_d;
  logic          rx_err_q, rx_err_d;
  logic          stuff_err_q, stuff_err_d;

  line_code_t lc;
  logic       decode, clear;
  logic       dbit, dbit_valid, stuff_viol;

  assign lc     = classify(d_plus, d_minus, IDLE_DP);
  assign decode = en_sample && (((state_q == IDLE) && (lc == LC_K)) ||
                                ((state_q == RCV) && (lc != LC_SE0)));

  rx_unstuffer #(
    .STUFF_LIMIT(STUFF_LIMIT),
    .IDLE_DP    (IDLE_DP)
  ) u_unstuffer (
    .clk       (clk),
    .rst       (rst),
    .d_plus    (d_plus),
    .decode    (decode),
    .clear     (clear),
    .dbit      (dbit),
    .dbit_valid(dbit_valid),
    .stuff_viol(stuff_viol)
  );

`ifndef RX_STUFF_ERR_EN
  logic stuff_viol_unused;
  assign stuff_viol_unused = stuff_viol;
`endif

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    rx_byte_d    = rx_byte_q;
    byte_ready_d = 1'b0;
    eop_d        = 1'b0;
    rx_err_d     = 1'b0;
    stuff_err_d  = 1'b0;
    clear        = 1'b0;
    if (en_sample) begin
      case (state_q)
        IDLE: begin
          if (lc == LC_K) state_d = RCV;
          else            state_d = IDLE;
        end
        RCV: begin
          if (lc == LC_SE0) state_d = EOP1;
          else              state_d = RCV;
        end
        EOP1: begin
          if (lc == LC_SE0) begin
            state_d = EOP2;
          end else begin
            rx_err_d = 1'b1;
            clear    = 1'b1;
            state_d  = IDLE;
          end
        end
        EOP2: begin
          case (lc)
            LC_J: begin
              // A partial byte at EOP is discarded and reported alongside eop.
              eop_d    = 1'b1;
              rx_err_d = (bit_cnt_q != 3'd0);
              clear    = 1'b1;
              state_d  = IDLE;
            end
            LC_K: begin
              rx_err_d = 1'b1;
              clear    = 1'b1;
              state_d  = IDLE;
            end
            default: state_d = EOP2;
          endcase
        end
        default: begin
          clear   = 1'b1;
          state_d = IDLE;
        end
      endcase

      if (dbit_valid) begin
        shift_d   = {dbit, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          rx_byte_d    = {dbit, shift_q[7:1]};
          byte_ready_d = 1'b1;
        end else begin
          byte_ready_d = 1'b0;
        end
      end else begin
        shift_d = shift_q;
      end

`ifdef RX_STUFF_ERR_EN
      if (stuff_viol) begin
        stuff_err_d = 1'b1;
        rx_err_d    = 1'b1;
        clear       = 1'b1;
        state_d     = IDLE;
      end else begin
        stuff_err_d = 1'b0;
      end
`endif

      if (clear) bit_cnt_d = 3'd0;
      else       bit_cnt_d = bit_cnt_d;
    end else begin
      state_d = state_q;
    end
    rx_active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= 8'h00;
      bit_cnt_q    <= 3'd0;
      rx_byte_q    <= 8'h00;
      rx_active_q  <= 1'b0;
      byte_ready_q <= 1'b0;
      eop_q        <= 1'b0;
      rx_err_q     <= 1'b0;
      stuff_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_byte_q    <= rx_byte_d;
      rx_active_q  <= rx_active_d;
      byte_ready_q <= byte_ready_d;
      eop_q        <= eop_d;
      rx_err_q     <= rx_err_d;
      stuff_err_q  <= stuff_err_d;
    end
  end

  assign rx_active  = rx_active_q;
  assign rx_byte    = rx_byte_q;
  assign byte_ready = byte_ready_q;
  assign eop        = eop_q;
  assign rx_err     = rx_err_q;
  assign stuff_err  = stuff_err_q;

endmodule

// File: tb/tb_rx_bit_decoder.sv
// Bench for rx_bit_decoder: a packet encoder (NRZI + stuffing) builds line
// samples together with the outputs each sample must produce.
module tb_rx_bit_decoder;

  logic       clk = 1'b0;
  logic       rst, d_plus, d_minus, en_sample;
  logic       rx_active, byte_ready, eop, rx_err, stuff_err;
  logic [7:0] rx_byte;

  always #5 clk = ~clk;

  rx_bit_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .d_plus    (d_plus),
    .d_minus   (d_minus),
    .en_sample (en_sample),
    .rx_active (rx_active),
    .rx_byte   (rx_byte),
    .byte_ready(byte_ready),
    .eop       (eop),
    .rx_err    (rx_err),
    .stuff_err (stuff_err)
  );

  typedef struct {
    logic       dp;
    logic       dm;
    logic       br;
    logic [7:0] rb;
    logic       eop;
    logic       err;
    logic       serr;
    logic       act;
  } vec_t;

  vec_t vq[$];
  vec_t tbl[9];
  int   errors = 0;
  int   checks = 0;

  // Encoder-side model: wire level, run of ones, bit position in byte.
  logic       m_level;
  int         m_ones;
  int         m_cnt;
  logic [7:0] m_cur;
  logic [7:0] m_last;
  logic       m_inject;

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d got=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  task automatic push(input logic dp, input logic dm, input logic br, input logic [7:0] rb,
                      input logic e, input logic er, input logic se, input logic ac);
    vec_t v;
    v.dp = dp; v.dm = dm; v.br = br; v.rb = rb;
    v.eop = e; v.err = er; v.serr = se; v.act = ac;
    vq.push_back(v);
  endtask

  task automatic model_reset();
    m_level  = 1'b1;
    m_ones   = 0;
    m_cnt    = 0;
    m_inject = 1'b0;
  endtask

  task automatic tx_data(input logic b);
    logic br;
    br = 1'b0;
    if (!b) m_level = ~m_level;
    m_cur[m_cnt] = b;
    m_cnt++;
    if (m_cnt == 8) begin
      br     = 1'b1;
      m_last = m_cur;
      m_cnt  = 0;
    end
    push(m_level, ~m_level, br, m_last, 1'b0, 1'b0, 1'b0, 1'b1);
    if (b) m_ones++;
    else   m_ones = 0;
    if (m_ones == 6) begin
      m_ones = 0;
      if (m_inject) begin
        m_inject = 1'b0;
`ifdef RX_STUFF_ERR_EN
        push(m_level, ~m_level, 1'b0, m_last, 1'b0, 1'b1, 1'b1, 1'b0);
        m_level = 1'b1;
        m_cnt   = 0;
`else
        push(m_level, ~m_level, 1'b0, m_last, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
      end else begin
        m_level = ~m_level;
        push(m_level, ~m_level, 1'b0, m_last, 1'b0, 1'b0, 1'b0, 1'b1);
      end
    end
  endtask

  task automatic tx_sync();
    for (int i = 0; i < 7; i++) tx_data(1'b0);
    tx_data(1'b1);
  endtask

  task automatic tx_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) tx_data(b[i]);
  endtask

  task automatic tx_eop(input logic se1_first);
    push(se1_first, se1_first, 1'b0, m_last, 1'b0, 1'b0, 1'b0, 1'b1);
    push(1'b0, 1'b0, 1'b0, m_last, 1'b0, 1'b0, 1'b0, 1'b1);
    push(1'b1, 1'b0, 1'b0, m_last, 1'b1, (m_cnt != 0), 1'b0, 1'b0);
    model_reset();
  endtask

  task automatic tx_idle(input int n);
    for (int i = 0; i < n; i++) push(1'b1, 1'b0, 1'b0, m_last, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic apply(input vec_t v, input int idx, input int gap);
    @(negedge clk);
    d_plus = v.dp; d_minus = v.dm; en_sample = 1'b1;
    @(posedge clk);
    #1;
    en_sample = 1'b0;
    chk("byte_ready", idx, {7'd0, byte_ready}, {7'd0, v.br});
    chk("rx_byte",    idx, rx_byte, v.rb);
    chk("eop",        idx, {7'd0, eop},       {7'd0, v.eop});
    chk("rx_err",     idx, {7'd0, rx_err},    {7'd0, v.err});
    chk("stuff_err",  idx, {7'd0, stuff_err}, {7'd0, v.serr});
    chk("rx_active",  idx, {7'd0, rx_active}, {7'd0, v.act});
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
      chk("hold_pulses", idx, {4'd0, byte_ready, eop, rx_err, stuff_err}, 8'h00);
      chk("hold_active", idx, {7'd0, rx_active}, {7'd0, v.act});
      chk("hold_byte",   idx, rx_byte, v.rb);
    end
  endtask

  task automatic run_queue(input logic rand_gaps);
    int n;
    n = vq.size();
    for (int i = 0; i < n; i++) apply(vq[i], i, rand_gaps ? int'($urandom_range(0, 2)) : 0);
    vq.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en_sample = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_outputs", -1, {3'd0, rx_active, byte_ready, eop, rx_err, stuff_err}, 8'h00);
    chk("reset_rx_byte", -1, rx_byte, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    m_last = 8'h00;
  endtask

  initial begin
    int nb, np;
    rst = 1'b1; d_plus = 1'b1; d_minus = 1'b0; en_sample = 1'b0;
    m_cur = 8'h00; m_last = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Sync pattern KJKJKJKK after an idle J, as a literal table.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) apply(tbl[i], i, 0);
    m_level = 1'b0; m_ones = 1; m_cnt = 0; m_last = 8'h80;

    // 0xFF straight after sync: stuff bit after six ones, then clean EOP.
    tx_byte(8'hFF);
    tx_eop(1'b0);
    tx_idle(2);
    run_queue(1'b0);

    // Stuff position carrying a 1.
    tx_sync();
    m_inject = 1'b1;
    for (int i = 0; i < 5; i++) tx_data(1'b1);
`ifdef RX_STUFF_ERR_EN
    tx_idle(2);
`else
    for (int i = 0; i < 3; i++) tx_data(1'b1);
    tx_eop(1'b0);
    tx_idle(1);
`endif
    run_queue(1'b0);

    // EOP1 broken by K.
    tx_sync(); tx_byte(8'hA5);
    push(1'b0, 1'b0, 1'b0, m_last, 1'b0, 1'b0, 1'b0, 1'b1);
    push(1'b0, 1'b1, 1'b0, m_last, 1'b0, 1'b1, 1'b0, 1'b0);
    model_reset(); tx_idle(2);
    // EOP2 broken by K.
    tx_sync(); tx_byte(8'h3C);
    push(1'b0, 1'b0, 1'b0, m_last, 1'b0, 1'b0, 1'b0, 1'b1);
    push(1'b0, 1'b0, 1'b0, m_last, 1'b0, 1'b0, 1'b0, 1'b1);
    push(1'b0, 1'b1, 1'b0, m_last, 1'b0, 1'b1, 1'b0, 1'b0);
    model_reset(); tx_idle(2);
    // Partial byte (3 bits) at EOP, first SE0 sent as SE1.
    tx_sync(); tx_data(1'b1); tx_data(1'b0); tx_data(1'b1);
    tx_eop(1'b1); tx_idle(1);
    // Long SE0 tolerated before J.
    tx_sync(); tx_byte(8'h96);
    for (int i = 0; i < 4; i++) push(1'b0, 1'b0, 1'b0, m_last, 1'b0, 1'b0, 1'b0, 1'b1);
    push(1'b1, 1'b0, 1'b0, m_last, 1'b1, 1'b0, 1'b0, 1'b0);
    model_reset(); tx_idle(1);
    run_queue(1'b0);

    // Reset mid-byte, then a fresh packet.
    tx_sync();
    for (int i = 0; i < 5; i++) tx_data(i[0]);
    run_queue(1'b0);
    do_reset();
    tx_sync(); tx_byte(8'h5A); tx_eop(1'b0); tx_idle(1);
    run_queue(1'b1);

    // Random valid packets with random sample spacing.
    for (int p = 0; p < 25; p++) begin
      tx_idle(int'($urandom_range(1, 3)));
      tx_sync();
      nb = int'($urandom_range(1, 3));
      for (int b = 0; b < nb; b++) tx_byte(($urandom % 4 == 0) ? 8'hFF : 8'($urandom));
      np = ($urandom % 5 == 0) ? int'($urandom_range(1, 7)) : 0;
      for (int b = 0; b < np; b++) tx_data(1'($urandom));
      tx_eop(1'($urandom));
      run_queue(1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
